// File: rtl/conv_prefetch_reader.sv
// conv_prefetch_reader
//
// Read-side adapter between a standard FIFO (1-cycle read latency) and a
// prefetch / first-word-fall-through consumer interface. A 2-entry buffer
// (head, tail) plus an in-flight flag keeps at most two words outstanding,
// which gives full 1 word/cycle throughput without overflow.
//
// Ports
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   flush         synchronous clear of buffered and in-flight data
//   fifo_empty    upstream FIFO empty flag
//   fifo_rd_en    upstream read strobe (combinational)
//   fifo_rd_data  upstream data, valid the cycle after fifo_rd_en
//   rd_en         consumer accept; ignored while rd_vld=0
//   rd_vld        rd_data holds a valid word
//   rd_data       head word
//   pf_cnt        buffered word count, 0..2
module conv_prefetch_reader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  rd_en,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            pf_cnt
);

  logic [1:0]            cnt;
  logic [1:0]            cnt_nxt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic [DATA_WIDTH-1:0] tail;
  logic [DATA_WIDTH-1:0] tail_nxt;
  logic                  pop;
  logic [1:0]            cnt_after_pop;
  logic [2:0]            occ_after;

  assign pop           = rd_en & (cnt != 2'd0);
  // pop implies cnt >= 1, so this never wraps.
  assign cnt_after_pop = cnt - {1'b0, pop};
  // Occupancy once the word already in flight has landed.
  assign occ_after     = {1'b0, cnt_after_pop} + {2'b00, inflight};

  // A new read is only issued when its word is guaranteed a free slot,
  // which is what rules out overflow of the 2-entry buffer.
  assign fifo_rd_en = rst_n & ~flush & ~fifo_empty & (occ_after < 3'd2);

  always_comb begin
    head_nxt = head;
    tail_nxt = tail;
    cnt_nxt  = cnt;
    if (flush) begin
      // Flush wins over pop and drops any word landing this cycle.
      cnt_nxt = 2'd0;
    end else begin
      if (pop && (cnt == 2'd2)) begin
        head_nxt = tail;
      end
      if (inflight) begin
        if (cnt_after_pop == 2'd0) begin
          head_nxt = fifo_rd_data;
        end else begin
          tail_nxt = fifo_rd_data;
        end
      end
      cnt_nxt = occ_after[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      rd_vld   <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      inflight <= fifo_rd_en;
      head     <= head_nxt;
      tail     <= tail_nxt;
      rd_vld   <= (cnt_nxt != 2'd0);
    end
  end

  assign rd_data = head;
  assign pf_cnt  = cnt;

endmodule

// File: tb/tb_conv_prefetch_reader.sv
module tb_conv_prefetch_reader;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       rd_en;
  logic       rd_vld;
  logic [7:0] rd_data;
  logic [1:0] pf_cnt;

  conv_prefetch_reader #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .rd_en        (rd_en),
    .rd_vld       (rd_vld),
    .rd_data      (rd_data),
    .pf_cnt       (pf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Upstream FIFO contents, consumer-visible buffer model, delivered words.
  logic [7:0] up_q[$];
  logic [7:0] m_buf[$];
  logic       m_inflight;
  logic [7:0] m_word;
  logic [7:0] got[$];
  int         got_cyc[$];
  logic       hold_empty;
  logic       last_rd_en;
  int         cyc_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_idx);
    end
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic cycle();
    int   occ;
    logic exp_pop;
    logic exp_rd_en;
    logic dut_rd_en;
    fifo_empty = hold_empty || (up_q.size() == 0);
    #3;
    occ       = m_buf.size();
    exp_pop   = rd_en && (occ != 0);
    exp_rd_en = !flush && !fifo_empty && ((occ + int'(m_inflight) - int'(exp_pop)) < 2);
    chk("rd_vld", rd_vld, occ != 0);
    chk("pf_cnt", pf_cnt, occ);
    if (occ != 0) chk("rd_data", rd_data, m_buf[0]);
    chk("fifo_rd_en", fifo_rd_en, exp_rd_en);
    chk("cnt_le_2", pf_cnt <= 2'd2, 1);
    dut_rd_en = fifo_rd_en;
    if (rd_en && rd_vld && !flush) begin
      got.push_back(rd_data);
      got_cyc.push_back(cyc_idx);
    end
    @(posedge clk);
    #1;
    if (flush) begin
      m_buf.delete();
    end else begin
      if (exp_pop) void'(m_buf.pop_front());
      if (m_inflight) m_buf.push_back(m_word);
    end
    m_inflight = exp_rd_en;
    if (exp_rd_en) m_word = (up_q.size() != 0) ? up_q[0] : 8'h00;
    if (dut_rd_en && (up_q.size() != 0)) fifo_rd_data = up_q.pop_front();
    else fifo_rd_data = 8'hEE;
    last_rd_en = dut_rd_en;
    cyc_idx++;
  endtask

  initial begin
    int pulses;
    logic [7:0] nw;
    rst_n        = 1'b0;
    flush        = 1'b0;
    rd_en        = 1'b1;
    fifo_empty   = 1'b0;
    fifo_rd_data = 8'hEE;
    hold_empty   = 1'b0;
    m_inflight   = 1'b0;
    m_word       = 8'h00;
    last_rd_en   = 1'b0;
    cyc_idx      = 0;

    // Reset state, with fifo_empty low so the read strobe gating is exercised.
    #2;
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_pf_cnt", pf_cnt, 0);
    chk("rst_fifo_rd_en", fifo_rd_en, 0);
    @(posedge clk); #1;
    chk("rst_hold_rd_en", fifo_rd_en, 0);
    rst_n = 1'b1;

    // Single word 0x5A, no consumer.
    rd_en = 1'b0;
    up_q.push_back(8'h5A);
    cycle();
    chk("single_rd_en_N", last_rd_en, 1);
    chk("single_vld_N1", rd_vld, 0);
    cycle();
    chk("single_vld_N2", rd_vld, 1);
    chk("single_data", rd_data, 8'h5A);
    chk("single_cnt", pf_cnt, 1);
    cycle();
    cycle();
    chk("single_hold_vld", rd_vld, 1);
    chk("single_hold_data", rd_data, 8'h5A);
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    chk("single_popped_vld", rd_vld, 0);
    chk("single_popped_cnt", pf_cnt, 0);

    // Stream of 16 words with rd_en held.
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 16; i++) up_q.push_back(8'(i));
    rd_en = 1'b1;
    for (int c = 0; c < 22; c++) cycle();
    rd_en = 1'b0;
    chk("stream_count", got.size(), 16);
    if (got.size() == 16) begin
      chk("stream_span", got_cyc[15] - got_cyc[0] + 1, 16);
      for (int i = 0; i < 16; i++) chk("stream_word", got[i], i);
    end

    // Backpressure: exactly two reads, then hold.
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 6; i++) up_q.push_back(8'hB0 + 8'(i));
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      pulses += int'(last_rd_en);
    end
    chk("bp_pulses", pulses, 2);
    chk("bp_cnt", pf_cnt, 2);
    chk("bp_head", rd_data, 8'hB0);
    cycle();
    chk("bp_no_more_rd", last_rd_en, 0);
    for (int c = 0; c < 30; c++) begin
      rd_en = (c % 2 == 0);
      cycle();
    end
    rd_en = 1'b0;
    chk("bp_count", got.size(), 6);
    if (got.size() == 6)
      for (int i = 0; i < 6; i++) chk("bp_word", got[i], 8'hB0 + i);

    // Flush while a read is in flight.
    up_q.push_back(8'hA0);
    up_q.push_back(8'hA1);
    up_q.push_back(8'hA2);
    cycle();
    chk("flush_pre_rd", last_rd_en, 1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_rd_forced_low", last_rd_en, 0);
    chk("flush_vld", rd_vld, 0);
    chk("flush_cnt", pf_cnt, 0);
    for (int c = 0; c < 4; c++) cycle();
    chk("flush_next_vld", rd_vld, 1);
    chk("flush_next_word", rd_data, 8'hA1);
    chk("flush_full", pf_cnt, 2);

    // Asynchronous reset with two words buffered.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_vld", rd_vld, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_pf_cnt", pf_cnt, 0);
    chk("arst_fifo_rd_en", fifo_rd_en, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_buf.delete();
    m_inflight   = 1'b0;
    fifo_rd_data = 8'hEE;

    // Random fifo_empty / rd_en / flush against the model.
    nw = 8'h40;
    for (int c = 0; c < 400; c++) begin
      hold_empty = ($urandom_range(0, 3) == 0);
      rd_en      = ($urandom_range(0, 1) == 1);
      flush      = ($urandom_range(0, 24) == 0);
      if ((up_q.size() < 3) && ($urandom_range(0, 1) == 1)) begin
        up_q.push_back(nw);
        nw++;
      end
      cycle();
    end
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
